ov7620_frame_capture: RTL and testbench
=======================================

# ov7620_frame_capture

Captures one windowed frame of 8-bit OV7620 pixel data into a frame-buffer write port. Sits directly downstream of the HREF filter stage and consumes its filtered line-valid level `L2H_Sig_H`. It also takes the raw VSYNC, PCLK and data pins, synchronises them into the `CLK` domain and counts columns and rows. It emits one buffer write per in-window pixel and a `Frame_Done` pulse at frame end.

## Interface
Parameters:
- `H_START`, 0, first captured column (pixels counted from line start).
- `H_WIDTH`, 320, captured columns per line.
- `V_START`, 0, first captured row (lines counted from VSYNC).
- `V_HEIGHT`, 240, captured rows.
- `ADDR_W`, 17, write-address width; must satisfy H_WIDTH*V_HEIGHT ≤ 2^ADDR_W.
- `CONTINUOUS`, 0, 1 = re-arm automatically after each frame.

Ports:
- `CLK`  in  1  system clock; must be ≥4× PCLK.
- `RSTn`  in  1  asynchronous, active-low reset.
- `Capture_Req`  in  1  level, arms one frame capture when sampled high in IDLE.
- `L2H_Sig_H`  in  1  filtered HREF level from the HREF filter stage (already in the `CLK` domain).
- `Pin_VSYNC`  in  1  raw sensor VSYNC, active high.
- `Pin_PCLK`  in  1  raw sensor pixel clock.
- `Pin_Data`  in  8  raw sensor pixel bus.
- `Wr_En`  out  1  one-cycle write strobe.
- `Wr_Addr`  out  ADDR_W  linear write address (row-major in window).
- `Wr_Data`  out  8  pixel for write.
- `Frame_Done`  out  1  one-cycle pulse at frame end.
- `Short_Frame`  out  1  sticky: last frame ended early by VSYNC.
- `Busy`  out  1  high in ARM/FRAME/DONE.

## Operation
- Synchronisers: `Pin_PCLK` and `Pin_VSYNC` each pass through 3 flops (F1, F2, F3). `pclk_rise = P_F2 & ~P_F3` and `vs_rise = V_F2 & ~V_F3`. `Pin_Data` passes through 2 flops (D_F1, D_F2), sampled on the same edges as P_F1 and P_F2.
- Line end: `href_d` registers `L2H_Sig_H`; `line_end = href_d & ~L2H_Sig_H`.
- Counters: `col` is 10 bits and `row` is 9 bits, both saturating at all-ones. `addr` is ADDR_W bits.
- FSM states:
  - IDLE: `Busy` = 0. If `Capture_Req` = 1, go to ARM and clear `Short_Frame`.
  - ARM: on `vs_rise`, clear `col`/`row`/`addr` and go to FRAME.
  - FRAME, pixels: on a `pclk_rise` while `L2H_Sig_H` = 1, the pixel is captured if H_START ≤ `col` < H_START+H_WIDTH and V_START ≤ `row` < V_START+V_HEIGHT. Capture sets `Wr_En` = 1, `Wr_Data` = D_F2, `Wr_Addr` = `addr`, then increments `addr`. `col` increments on every such `pclk_rise`, in window or not.
  - FRAME, line end: on `line_end`, `col` ← 0 and `row` ← `row`+1. If the new `row` equals V_START+V_HEIGHT, go to DONE.
  - FRAME, early VSYNC: on `vs_rise`, set `Short_Frame` and go to DONE.
  - DONE: pulse `Frame_Done` for one cycle. Go to ARM if CONTINUOUS = 1 (`Short_Frame` is not cleared), else IDLE.
- Simultaneous `line_end` and `vs_rise` in FRAME: `line_end` is evaluated first. If it completes the frame, the exit is a normal DONE and `Short_Frame` stays 0.
- Simultaneous `pclk_rise` and `line_end`: the pixel is written with the pre-increment `col`/`row`, then `col` is cleared.
- `Capture_Req` outside IDLE is ignored. `Pin_PCLK` and `Pin_Data` activity in IDLE/ARM produces no writes.
- Reset (any time, including mid-frame): FSM → IDLE. All outputs, counters and synchroniser flops → 0. A partially written frame is abandoned and no `Frame_Done` is issued.

## Timing
- Edge k is the first `CLK` edge that samples `Pin_PCLK` high. `Wr_En` is registered at edge k+2, high for exactly one cycle. `Wr_Data` equals `Pin_Data` as sampled at edge k.
- `Pin_PCLK` high and low phases must each be ≥2 `CLK` cycles. `Pin_Data` must be stable from one cycle before edge k through edge k.
- `Frame_Done` is high in the cycle after the FSM enters DONE. It comes 2 cycles after the final `line_end` detection, or 2 cycles after the aborting `vs_rise`.
- `Wr_En` never asserts in the same cycle as `Frame_Done`.
- Maximum throughput: one write per PCLK period.

## Test plan
- Nominal frame: H_START = 1, H_WIDTH = 4, V_START = 1, V_HEIGHT = 3; sensor model drives 4 lines of 6 pixels, value = row*16+col → 12 writes, addr 0..11, data 0x11..0x14, 0x21..0x24, 0x31..0x34, then one `Frame_Done` pulse; `Short_Frame` = 0; `Busy` falls.
- Early VSYNC: same parameters, VSYNC rises after 2 lines → 4 writes (0x11..0x14), `Frame_Done` pulse, `Short_Frame` = 1; next `Capture_Req` clears it.
- Not armed: pixels and VSYNC with `Capture_Req` = 0 → zero writes; `Busy` = 0 throughout.
- Reset mid-frame: assert `RSTn` = 0 after 5 writes → all outputs 0 immediately, no `Frame_Done`; the next armed frame starts at `Wr_Addr` = 0.
- CONTINUOUS = 1: 3 consecutive VSYNC-framed frames, a single `Capture_Req` → 3 `Frame_Done` pulses, each frame writing addr 0..11.
- Latency check: PCLK = CLK/4, single pixel 0xA5 → `Wr_En` high exactly one cycle, 2 edges after first PCLK-high sample, `Wr_Data` = 0xA5.

Source files
------------

// File: rtl/ov7620_frame_capture.sv
// OV7620 frame capture: synchronises raw PCLK/VSYNC/data into CLK, counts
// columns and rows, and writes one windowed frame to a linear buffer port.
module ov7620_frame_capture #(
    parameter int H_START    = 0,
    parameter int H_WIDTH    = 320,
    parameter int V_START    = 0,
    parameter int V_HEIGHT   = 240,
    parameter int ADDR_W     = 17,
    parameter bit CONTINUOUS = 1'b0
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              Capture_Req,
    input  logic              L2H_Sig_H,
    input  logic              Pin_VSYNC,
    input  logic              Pin_PCLK,
    input  logic [7:0]        Pin_Data,
    output logic              Wr_En,
    output logic [ADDR_W-1:0] Wr_Addr,
    output logic [7:0]        Wr_Data,
    output logic              Frame_Done,
    output logic              Short_Frame,
    output logic              Busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARM   = 2'd1;
    localparam logic [1:0] ST_FRAME = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int H_END = H_START + H_WIDTH;
    localparam int V_END = V_START + V_HEIGHT;

    logic [1:0]        state;
    logic              p_f1, p_f2, p_f3;
    logic              v_f1, v_f2, v_f3;
    logic [7:0]        d_f1, d_f2;
    logic              href_d;
    logic [9:0]        col;
    logic [8:0]        row;
    logic [ADDR_W-1:0] addr;

    logic              pclk_rise, vs_rise, line_end, pixel;
    logic              in_window, frame_complete;
    logic [9:0]        col_inc;
    logic [8:0]        row_inc;
    int                col_i, row_i, row_inc_i;

    assign pclk_rise = p_f2 & ~p_f3;
    assign vs_rise   = v_f2 & ~v_f3;
    assign line_end  = href_d & ~L2H_Sig_H;
    assign pixel     = pclk_rise & L2H_Sig_H;
    assign Busy      = (state != ST_IDLE);

    // Counters stick at all-ones so an oversized sensor frame cannot wrap back into the window.
    assign col_inc = (&col) ? col : col + 10'd1;
    assign row_inc = (&row) ? row : row + 9'd1;

    always_comb begin
        col_i          = {22'd0, col};
        row_i          = {23'd0, row};
        row_inc_i      = {23'd0, row_inc};
        in_window      = (col_i >= H_START) && (col_i < H_END) &&
                         (row_i >= V_START) && (row_i < V_END);
        frame_complete = line_end && (row_inc_i == V_END);
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            p_f1   <= 1'b0;
            p_f2   <= 1'b0;
            p_f3   <= 1'b0;
            v_f1   <= 1'b0;
            v_f2   <= 1'b0;
            v_f3   <= 1'b0;
            d_f1   <= 8'd0;
            d_f2   <= 8'd0;
            href_d <= 1'b0;
        end else begin
            p_f1   <= Pin_PCLK;
            p_f2   <= p_f1;
            p_f3   <= p_f2;
            v_f1   <= Pin_VSYNC;
            v_f2   <= v_f1;
            v_f3   <= v_f2;
            d_f1   <= Pin_Data;
            d_f2   <= d_f1;
            href_d <= L2H_Sig_H;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state       <= ST_IDLE;
            col         <= '0;
            row         <= '0;
            addr        <= '0;
            Wr_En       <= 1'b0;
            Wr_Addr     <= '0;
            Wr_Data     <= 8'd0;
            Frame_Done  <= 1'b0;
            Short_Frame <= 1'b0;
        end else begin
            Wr_En      <= 1'b0;
            Frame_Done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Capture_Req) begin
                        Short_Frame <= 1'b0;
                        state       <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (vs_rise) begin
                        col   <= '0;
                        row   <= '0;
                        addr  <= '0;
                        state <= ST_FRAME;
                    end
                end
                ST_FRAME: begin
                    if (pixel) begin
                        col <= col_inc;
                        if (in_window) begin
                            Wr_En   <= 1'b1;
                            Wr_Data <= d_f2;
                            Wr_Addr <= addr;
                            addr    <= addr + ADDR_W'(1);
                        end
                    end
                    if (line_end) begin
                        col <= '0;
                        row <= row_inc;
                    end
                    // A line end that completes the frame wins over a coincident VSYNC.
                    if (frame_complete) begin
                        state <= ST_DONE;
                    end else if (vs_rise) begin
                        Short_Frame <= 1'b1;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    Frame_Done <= 1'b1;
                    state      <= CONTINUOUS ? ST_ARM : ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ov7620_frame_capture.sv
// Bench for ov7620_frame_capture: sensor/HREF driver, frame-level reference
// model with a write scoreboard, one single-shot and one continuous instance.
module tb_ov7620_frame_capture;

    localparam int HS = 1;
    localparam int HW = 4;
    localparam int VS = 1;
    localparam int VH = 3;
    localparam int AW = 17;

    logic          CLK = 1'b0;
    logic          RSTn_a, RSTn_b, Req_a, Req_b;
    logic          L2H_Sig_H, Pin_VSYNC, Pin_PCLK;
    logic [7:0]    Pin_Data;
    logic          Wr_En_a, Wr_En_b, Frame_Done_a, Frame_Done_b;
    logic          Short_Frame_a, Short_Frame_b, Busy_a, Busy_b;
    logic [AW-1:0] Wr_Addr_a, Wr_Addr_b;
    logic [7:0]    Wr_Data_a, Wr_Data_b;

    always #5 CLK = ~CLK;

    ov7620_frame_capture #(.H_START(HS), .H_WIDTH(HW), .V_START(VS), .V_HEIGHT(VH),
                           .ADDR_W(AW), .CONTINUOUS(1'b0)) dut_a (
        .CLK(CLK), .RSTn(RSTn_a), .Capture_Req(Req_a), .L2H_Sig_H(L2H_Sig_H),
        .Pin_VSYNC(Pin_VSYNC), .Pin_PCLK(Pin_PCLK), .Pin_Data(Pin_Data),
        .Wr_En(Wr_En_a), .Wr_Addr(Wr_Addr_a), .Wr_Data(Wr_Data_a),
        .Frame_Done(Frame_Done_a), .Short_Frame(Short_Frame_a), .Busy(Busy_a));

    ov7620_frame_capture #(.H_START(HS), .H_WIDTH(HW), .V_START(VS), .V_HEIGHT(VH),
                           .ADDR_W(AW), .CONTINUOUS(1'b1)) dut_b (
        .CLK(CLK), .RSTn(RSTn_b), .Capture_Req(Req_b), .L2H_Sig_H(L2H_Sig_H),
        .Pin_VSYNC(Pin_VSYNC), .Pin_PCLK(Pin_PCLK), .Pin_Data(Pin_Data),
        .Wr_En(Wr_En_b), .Wr_Addr(Wr_Addr_b), .Wr_Data(Wr_Data_b),
        .Frame_Done(Frame_Done_b), .Short_Frame(Short_Frame_b), .Busy(Busy_b));

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    // Frame-level model: 0 = not armed, 1 = waiting for VSYNC, 2 = capturing.
    wr_t q_a[$];
    wr_t q_b[$];
    int  m_st[2];
    int  m_row[2];
    int  m_addr[2];
    int  m_done[2];
    bit  m_short[2];
    int  seen_done[2];
    int  seen_wr[2];
    int  last_addr_a, last_data_a;
    int  n_cmp = 0;
    int  n_bad = 0;
    bit  expect_idle = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_req(input int i);
        if (m_st[i] == 0) begin
            m_st[i]    = 1;
            m_short[i] = 1'b0;
        end
    endfunction

    function automatic void m_finish(input int i, input bit early);
        m_done[i]++;
        if (early) m_short[i] = 1'b1;
        m_st[i] = (i == 1) ? 1 : 0;
    endfunction

    function automatic void m_vsync();
        for (int i = 0; i < 2; i++) begin
            if (m_st[i] == 2) m_finish(i, 1'b1);
            else if (m_st[i] == 1) begin
                m_st[i]   = 2;
                m_row[i]  = 0;
                m_addr[i] = 0;
            end
        end
    endfunction

    function automatic void m_pixel(input int col, input logic [7:0] v);
        wr_t w;
        for (int i = 0; i < 2; i++) begin
            if (m_st[i] == 2 && col >= HS && col < HS + HW && m_row[i] >= VS && m_row[i] < VS + VH) begin
                w.addr = AW'(m_addr[i]);
                w.data = v;
                m_addr[i]++;
                if (i == 0) q_a.push_back(w);
                else q_b.push_back(w);
            end
        end
    endfunction

    function automatic void m_line_end();
        for (int i = 0; i < 2; i++) begin
            if (m_st[i] == 2) begin
                m_row[i]++;
                if (m_row[i] == VS + VH) m_finish(i, 1'b0);
            end
        end
    endfunction

    task automatic cmp_port(input int i, input logic en, input logic [AW-1:0] addr,
                            input logic [7:0] data, input logic done);
        wr_t w;
        if (done) begin
            seen_done[i]++;
            check("wr_with_done", en, 1'b0);
        end
        if (en) begin
            seen_wr[i]++;
            if (i == 0) begin
                last_addr_a = addr;
                last_data_a = data;
            end
            if ((i == 0 ? q_a.size() : q_b.size()) == 0) begin
                check(i == 0 ? "unexpected_wr_a" : "unexpected_wr_b", en, 1'b0);
            end else begin
                if (i == 0) w = q_a.pop_front();
                else w = q_b.pop_front();
                check(i == 0 ? "wr_addr_a" : "wr_addr_b", addr, w.addr);
                check(i == 0 ? "wr_data_a" : "wr_data_b", data, w.data);
            end
        end
    endtask

    always @(negedge CLK) begin
        cmp_port(0, Wr_En_a, Wr_Addr_a, Wr_Data_a, Frame_Done_a);
        cmp_port(1, Wr_En_b, Wr_Addr_b, Wr_Data_b, Frame_Done_b);
        if (expect_idle) check("idle_busy_a", Busy_a, 1'b0);
    end

    task automatic checkpoint(input string tag);
        repeat (6) @(negedge CLK);
        check({tag, "_done_a"}, seen_done[0], m_done[0]);
        check({tag, "_done_b"}, seen_done[1], m_done[1]);
        check({tag, "_short_a"}, Short_Frame_a, m_short[0]);
        check({tag, "_busy_a"}, Busy_a, m_st[0] != 0);
        check({tag, "_busy_b"}, Busy_b, m_st[1] != 0);
        check({tag, "_pending_a"}, q_a.size(), 0);
        check({tag, "_pending_b"}, q_b.size(), 0);
    endtask

    task automatic pulse_req(input int i);
        if (i == 0) Req_a = 1'b1;
        else Req_b = 1'b1;
        m_req(i);
        @(negedge CLK);
        Req_a = 1'b0;
        Req_b = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic drive_vsync();
        Pin_VSYNC = 1'b1;
        m_vsync();
        repeat (4) @(negedge CLK);
        Pin_VSYNC = 1'b0;
        repeat (4) @(negedge CLK);
    endtask

    task automatic drive_pixel(input int col, input logic [7:0] v, input bit lat);
        int lo, hi;
        lo = lat ? 2 : $urandom_range(2, 4);
        hi = $urandom_range(2, 4);
        Pin_Data = v;
        m_pixel(col, v);
        repeat (lo) @(negedge CLK);
        Pin_PCLK = 1'b1;
        if (lat) begin
            @(negedge CLK); check("lat_k_en", Wr_En_a, 1'b0);
            @(negedge CLK); check("lat_k1_en", Wr_En_a, 1'b0);
            Pin_PCLK = 1'b0;
            @(negedge CLK); check("lat_k2_en", Wr_En_a, 1'b1);
            check("lat_k2_data", Wr_Data_a, 8'hA5);
            @(negedge CLK); check("lat_k3_en", Wr_En_a, 1'b0);
        end else begin
            repeat (hi) @(negedge CLK);
            Pin_PCLK = 1'b0;
        end
    endtask

    // VSYNC, when requested, is raised so its rising edge is detected on the same cycle as the line end.
    task automatic line_finish(input bit vs_at_end);
        @(negedge CLK);
        if (vs_at_end) Pin_VSYNC = 1'b1;
        repeat (2) @(negedge CLK);
        L2H_Sig_H = 1'b0;
        m_line_end();
        if (vs_at_end) m_vsync();
        repeat (4) @(negedge CLK);
        Pin_VSYNC = 1'b0;
        repeat ($urandom_range(2, 5)) @(negedge CLK);
    endtask

    task automatic drive_line(input int row, input int npix, input bit pattern,
                              input int lat_col, input bit vs_at_end);
        logic [7:0] v;
        L2H_Sig_H = 1'b1;
        repeat (2) @(negedge CLK);
        for (int c = 0; c < npix; c++) begin
            v = pattern ? 8'(row * 16 + c) : 8'($urandom);
            if (c == lat_col) v = 8'hA5;
            drive_pixel(c, v, c == lat_col);
        end
        line_finish(vs_at_end);
    endtask

    task automatic drive_frame(input int nlines, input bit pattern);
        drive_vsync();
        for (int r = 0; r < nlines; r++) drive_line(r, 6, pattern, -1, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0; m_row[i] = 0; m_addr[i] = 0; m_done[i] = 0;
            m_short[i] = 1'b0; seen_done[i] = 0; seen_wr[i] = 0;
        end
        RSTn_a = 1'b0; RSTn_b = 1'b0; Req_a = 1'b0; Req_b = 1'b0;
        L2H_Sig_H = 1'b0; Pin_VSYNC = 1'b0; Pin_PCLK = 1'b0; Pin_Data = 8'd0;
        repeat (3) @(negedge CLK);
        check("rst_wr_en", Wr_En_a, 1'b0);
        check("rst_wr_addr", Wr_Addr_a, 0);
        check("rst_wr_data", Wr_Data_a, 0);
        check("rst_frame_done", Frame_Done_a, 1'b0);
        check("rst_short", Short_Frame_a, 1'b0);
        check("rst_busy_a", Busy_a, 1'b0);
        check("rst_busy_b", Busy_b, 1'b0);
        RSTn_a = 1'b1; RSTn_b = 1'b1;
        repeat (2) @(negedge CLK);

        // Sensor traffic with no capture request.
        expect_idle = 1'b1;
        drive_frame(4, 1'b0);
        expect_idle = 1'b0;
        checkpoint("unarmed");

        // Nominal windowed frame.
        w0 = seen_wr[0];
        pulse_req(0);
        drive_frame(4, 1'b1);
        checkpoint("nominal");
        check("nom_writes", seen_wr[0] - w0, 12);
        check("nom_last_addr", last_addr_a, 11);
        check("nom_last_data", last_data_a, 8'h34);
        check("nom_done", seen_done[0], 1);

        // Frame cut short by VSYNC after two lines.
        w0 = seen_wr[0];
        pulse_req(0);
        drive_frame(2, 1'b1);
        drive_vsync();
        checkpoint("early");
        check("early_writes", seen_wr[0] - w0, 4);
        check("early_last_data", last_data_a, 8'h14);
        check("early_short", Short_Frame_a, 1'b1);
        pulse_req(0);
        check("req_clears_short", Short_Frame_a, 1'b0);
        drive_frame(4, 1'b0);
        checkpoint("after_early");

        // Final line end coincides with VSYNC: normal completion.
        pulse_req(0);
        drive_frame(3, 1'b0);
        drive_line(3, 6, 1'b0, -1, 1'b1);
        checkpoint("coincide");
        check("coincide_short", Short_Frame_a, 1'b0);

        // Reset in the middle of a frame after five writes.
        w0 = seen_wr[0];
        pulse_req(0);
        drive_frame(2, 1'b1);
        L2H_Sig_H = 1'b1;
        repeat (2) @(negedge CLK);
        drive_pixel(0, 8'h20, 1'b0);
        drive_pixel(1, 8'h21, 1'b0);
        repeat (3) @(negedge CLK);
        check("pre_rst_writes", seen_wr[0] - w0, 5);
        RSTn_a = 1'b0;
        #1;
        check("midrst_wr_en", Wr_En_a, 1'b0);
        check("midrst_wr_addr", Wr_Addr_a, 0);
        check("midrst_wr_data", Wr_Data_a, 0);
        check("midrst_busy", Busy_a, 1'b0);
        check("midrst_short", Short_Frame_a, 1'b0);
        m_st[0] = 0;
        m_short[0] = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RSTn_a = 1'b1;
        line_finish(1'b0);
        checkpoint("midrst");
        pulse_req(0);
        drive_frame(4, 1'b0);
        checkpoint("post_rst");

        // Single pixel latency with PCLK = CLK/4.
        pulse_req(0);
        drive_vsync();
        drive_line(0, 6, 1'b0, -1, 1'b0);
        drive_line(1, 6, 1'b0, 1, 1'b0);
        drive_line(2, 6, 1'b0, -1, 1'b0);
        drive_line(3, 6, 1'b0, -1, 1'b0);
        checkpoint("latency");

        // Randomised frames: variable line counts, widths and data.
        for (int f = 0; f < 6; f++) begin
            if (m_st[0] == 0) pulse_req(0);
            drive_vsync();
            for (int r = $urandom_range(2, 5); r > 0; r--) drive_line(0, $urandom_range(3, 8), 1'b0, -1, 1'b0);
            checkpoint("random");
        end
        if (m_st[0] == 2) drive_vsync();
        checkpoint("random_end");

        // Continuous instance: one request, three frames.
        w0 = seen_wr[1];
        pulse_req(1);
        for (int f = 0; f < 3; f++) drive_frame(4, 1'b1);
        checkpoint("continuous");
        check("cont_done_cnt", seen_done[1], 3);
        check("cont_writes", seen_wr[1] - w0, 36);
        check("cont_busy", Busy_b, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
